// File: rtl/eth_link_sequencer.sv
// eth_link_sequencer
//   Brings up and recovers the two transceiver channels (ss0, ss1) feeding
//   the RDMA datapath. For each channel: holds the core in reset, releases
//   it, waits (with timeout) for channel_up, debounces it into link_ready,
//   and re-runs the sequence after a link loss or a timeout. Timeouts are
//   counted (saturating) for software status.
//
// Ports
//   axi_clk            sole clock
//   axi_resetn         asynchronous active-low reset
//   enable             1 = sequencing allowed, 0 = hold both cores in reset
//   clear_counts       one-cycle pulse, zeroes both retry counters
//   ssN_channel_up     channel up from core N (asynchronous to axi_clk)
//   ssN_core_reset     active-high reset to core N
//   ssN_link_ready     channel N debounced up
//   ssN_retry_count    saturating count of channel N timeouts
//   link_lost[1:0]     one-cycle pulse per channel on READY -> down (bit0 = ss0)
//   all_links_ready    both channels ready
module eth_link_sequencer #(
  parameter int unsigned RESET_CYCLES    = 1000,
  parameter int unsigned LINK_TIMEOUT    = 2000000,
  parameter int unsigned DEBOUNCE_CYCLES = 256,
  parameter int unsigned HOLDOFF_CYCLES  = 1000
) (
  input  logic       axi_clk,
  input  logic       axi_resetn,
  input  logic       enable,
  input  logic       clear_counts,
  input  logic       ss0_channel_up,
  input  logic       ss1_channel_up,
  output logic       ss0_core_reset,
  output logic       ss1_core_reset,
  output logic       ss0_link_ready,
  output logic       ss1_link_ready,
  output logic [7:0] ss0_retry_count,
  output logic [7:0] ss1_retry_count,
  output logic [1:0] link_lost,
  output logic       all_links_ready
);

  typedef enum logic [2:0] {
    ST_DISABLED,
    ST_RESET,
    ST_WAIT_UP,
    ST_DEBOUNCE,
    ST_READY,
    ST_HOLDOFF
  } state_t;

  // Two-flop synchronizer for the asynchronous channel_up inputs.
  logic [1:0] up_meta;
  logic [1:0] up_sync;

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      up_meta <= '0;
      up_sync <= '0;
    end else begin
      up_meta <= {ss1_channel_up, ss0_channel_up};
      up_sync <= up_meta;
    end
  end

  logic [1:0] core_reset_v;
  logic [1:0] link_ready_v;
  logic [1:0] link_lost_v;
  logic [7:0] retry_v [2];

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    state_t      state;
    logic [31:0] cnt;
    logic [7:0]  retry;
    logic        lost;

    // cnt is loaded with the phase length on entry and the phase ends on
    // the edge where it reads 1, so each phase lasts exactly its parameter.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
        state <= ST_DISABLED;
        cnt   <= '0;
        retry <= '0;
        lost  <= 1'b0;
      end else begin
        lost <= 1'b0;
        if (clear_counts) begin
          retry <= '0;
        end
        if (!enable) begin
          state <= ST_DISABLED;
        end else begin
          case (state)
            ST_DISABLED: begin
              state <= ST_RESET;
              cnt   <= RESET_CYCLES;
            end
            ST_RESET: begin
              if (cnt == 32'd1) begin
                state <= ST_WAIT_UP;
                cnt   <= LINK_TIMEOUT;
              end else begin
                cnt <= cnt - 32'd1;
              end
            end
            ST_WAIT_UP: begin
              if (up_sync[ch]) begin
                state <= ST_DEBOUNCE;
                cnt   <= DEBOUNCE_CYCLES;
              end else if (cnt == 32'd1) begin
                state <= ST_RESET;
                cnt   <= RESET_CYCLES;
                // A coincident clear_counts wins over the increment.
                if (!clear_counts && (retry != 8'hFF)) begin
                  retry <= retry + 8'd1;
                end
              end else begin
                cnt <= cnt - 32'd1;
              end
            end
            ST_DEBOUNCE: begin
              if (!up_sync[ch]) begin
                state <= ST_WAIT_UP;
                cnt   <= LINK_TIMEOUT;
              end else if (cnt == 32'd1) begin
                state <= ST_READY;
              end else begin
                cnt <= cnt - 32'd1;
              end
            end
            ST_READY: begin
              if (!up_sync[ch]) begin
                state <= ST_HOLDOFF;
                cnt   <= HOLDOFF_CYCLES;
                lost  <= 1'b1;
              end
            end
            ST_HOLDOFF: begin
              if (cnt == 32'd1) begin
                state <= ST_RESET;
                cnt   <= RESET_CYCLES;
              end else begin
                cnt <= cnt - 32'd1;
              end
            end
            default: begin
              state <= ST_DISABLED;
            end
          endcase
        end
      end
    end

    assign core_reset_v[ch] = (state == ST_DISABLED) || (state == ST_RESET);
    assign link_ready_v[ch] = (state == ST_READY);
    assign link_lost_v[ch]  = lost;
    assign retry_v[ch]      = retry;
  end

  assign ss0_core_reset  = core_reset_v[0];
  assign ss1_core_reset  = core_reset_v[1];
  assign ss0_link_ready  = link_ready_v[0];
  assign ss1_link_ready  = link_ready_v[1];
  assign ss0_retry_count = retry_v[0];
  assign ss1_retry_count = retry_v[1];
  assign link_lost       = link_lost_v;
  assign all_links_ready = &link_ready_v;

endmodule

// File: doc/eth_link_sequencer.md
Name: eth_link_sequencer

Overview:
- Per-channel link bring-up and recovery sequencer for the two Ethernet/streaming channels (ss0, ss1) that feed the RDMA datapath.
- Holds each channel's transceiver core in reset, releases it, and waits for channel_up with a timeout.
- Debounces link-up, declares link_ready, and on link loss or timeout re-runs the reset sequence. Counts retries for software status.
- Sits between the channel cores and the status register block.

Parameters:
- RESET_CYCLES, 1000: cycles core_reset is held high per attempt (≥1).
- LINK_TIMEOUT, 2000000: cycles to wait for channel_up after reset release (≥1).
- DEBOUNCE_CYCLES, 256: cycles channel_up must stay high before link_ready (≥1).
- HOLDOFF_CYCLES, 1000: quiet cycles after link loss before re-reset (≥1).

Ports:
- axi_clk, in, 1: sole clock.
- axi_resetn, in, 1: asynchronous active-low reset.
- enable, in, 1: 1 = sequencing allowed; 0 = hold both cores in reset.
- clear_counts, in, 1: single-cycle pulse, zeroes both retry counters.
- ss0_channel_up, in, 1: channel 0 up, asynchronous to axi_clk.
- ss1_channel_up, in, 1: channel 1 up, asynchronous to axi_clk.
- ss0_core_reset, out, 1: active-high reset to channel 0 core.
- ss1_core_reset, out, 1: active-high reset to channel 1 core.
- ss0_link_ready, out, 1: channel 0 debounced up.
- ss1_link_ready, out, 1: channel 1 debounced up.
- ss0_retry_count, out, 8: saturating count of channel 0 timeouts.
- ss1_retry_count, out, 8: saturating count of channel 1 timeouts.
- link_lost, out, 2: one-cycle pulse per channel (bit0 = ss0) on a READY→down transition.
- all_links_ready, out, 1: ss0_link_ready & ss1_link_ready.

Behaviour:
- Reset values:
  - core_reset = 1 (both channels).
  - link_ready = 0, retry_count = 0, link_lost = 0, all_links_ready = 0.
  - All FSMs in DISABLED; sync flops = 0.
- Each channel_up passes through a 2-flop synchronizer, giving 2 cycles of latency. "up" below means the synchronized value.
- The two channels run identical, independent FSMs with 32-bit down-counters. Counters load with the parameter value on state entry.
- DISABLED:
  - core_reset = 1.
  - When enable = 1, go to RESET.
- RESET:
  - core_reset = 1 for exactly RESET_CYCLES cycles.
  - Then go to WAIT_UP, loading LINK_TIMEOUT.
- WAIT_UP:
  - core_reset = 0.
  - If up = 1, go to DEBOUNCE, loading DEBOUNCE_CYCLES. This takes priority over timeout in the same cycle.
  - Otherwise, on counter expiry after LINK_TIMEOUT cycles: go to RESET and increment retry_count, saturating at 255.
- DEBOUNCE:
  - core_reset = 0.
  - If up = 0, go to WAIT_UP and reload LINK_TIMEOUT.
  - When the counter has been 1 with up = 1, go to READY.
- READY:
  - link_ready = 1, core_reset = 0.
  - If up = 0, go to HOLDOFF, loading HOLDOFF_CYCLES.
  - link_lost[ch] pulses 1 cycle, coincident with the first HOLDOFF cycle.
- HOLDOFF:
  - core_reset = 0, link_ready = 0.
  - After HOLDOFF_CYCLES cycles, go to RESET. No retry increment.
- Output timing:
  - link_ready and core_reset are decoded directly from registered state, with no extra latency.
  - Link-up latency: if E0 is the edge first sampling channel_up = 1, link_ready goes high after edge E0+DEBOUNCE_CYCLES+2.
- enable = 0:
  - Any state goes to DISABLED on the next edge; core_reset and link_ready change the same edge.
  - No link_lost pulse. retry_count is held.
- clear_counts:
  - Zeroes both counters.
  - If it coincides with a timeout increment, clear wins and the result is 0.
- Asynchronous reset mid-sequence immediately forces reset values; all counters are discarded.
- link_lost pulses on both channels in the same cycle are allowed and independent.

Test Plan:
- Params RESET=4, TIMEOUT=10, DEBOUNCE=4, HOLDOFF=3; release reset, enable = 1, channel_up = 0 → core_reset high 4 cycles, low 10 cycles, high 4 again. Retry increments every 14 cycles; after 300 timeouts retry_count = 255.
- enable = 1, ss0_channel_up rises mid-WAIT_UP at edge E0 → ss0_link_ready rises after E0+6. all_links_ready stays 0 until ss1 is also ready.
- In DEBOUNCE, drop channel_up for 1 cycle at debounce count 2 → returns to WAIT_UP with full timeout, no retry increment. Link becomes ready only after 4 fresh stable cycles.
- In READY, drop ss1_channel_up → link_lost = 2'b10 for exactly one cycle. ss1_link_ready falls on the same edge, core_reset stays low 3 cycles, then goes high 4 cycles.
- clear_counts asserted on the same edge as a timeout with retry_count = 7 → retry_count = 0. The next timeout gives 1.
- enable deasserted in READY, and separately axi_resetn pulsed low mid-RESET → both core_reset = 1 and link_ready = 0 immediately (async reset) or next edge (enable). retry_count is preserved only in the enable case.
